// File: rtl/seg7_scan.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan
//  Brief    : Multiplexed 7-segment driver with blanking gap and frame-synced
//             double buffering of the displayed value.
//  Revision : 1.0
// ============================================================================
module seg7_scan #(
    parameter int DIGITS       = 4,
    parameter int SLOT_CYCLES  = 3000,
    parameter int BLANK_CYCLES = 150
) (
    input  logic                  BJ_CLK,
    input  logic                  RESET_N,
    input  logic                  LOAD,
    input  logic [4*DIGITS-1:0]   DATA,
    input  logic [DIGITS-1:0]     DP_IN,
    input  logic [DIGITS-1:0]     DIGIT_EN,
    output logic [6:0]            SEG_N,
    output logic                  DP_N,
    output logic [DIGITS-1:0]     AN_N,
    output logic                  FRAME_DONE
);

    localparam int c_cnt_w = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int c_idx_w = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [c_cnt_w-1:0] c_slot_last = c_cnt_w'(SLOT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_blank     = c_cnt_w'(BLANK_CYCLES);
    localparam logic [c_idx_w-1:0] c_idx_last  = c_idx_w'(DIGITS - 1);

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } phase_t;

    phase_t                 r_phase;
    phase_t                 w_phase_next;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [c_cnt_w-1:0]     w_cnt_next;
    logic [c_idx_w-1:0]     r_idx;
    logic [c_idx_w-1:0]     w_idx_next;
    logic                   w_slot_wrap;
    logic                   w_frame_wrap;
    logic                   w_show;

    logic [4*DIGITS-1:0]    r_pend_data;
    logic [DIGITS-1:0]      r_pend_dp;
    logic [DIGITS-1:0]      r_pend_en;
    logic [4*DIGITS-1:0]    r_act_data;
    logic [DIGITS-1:0]      r_act_dp;
    logic [DIGITS-1:0]      r_act_en;

    logic [3:0]             w_nib;
    logic                   w_dp;
    logic                   w_en;
    logic [6:0]             w_seg_dec;
    logic [DIGITS-1:0]      w_an_next;

    // Slot / digit sequencing
    always_comb begin
        w_slot_wrap  = (r_cnt == c_slot_last);
        w_frame_wrap = w_slot_wrap && (r_idx == c_idx_last);
        w_cnt_next   = w_slot_wrap ? '0 : r_cnt + 1'b1;
        if (w_frame_wrap) begin
            w_idx_next = '0;
        end else if (w_slot_wrap) begin
            w_idx_next = r_idx + 1'b1;
        end else begin
            w_idx_next = r_idx;
        end
    end

    always_ff @(posedge BJ_CLK) begin
        if (!RESET_N) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else begin
            r_cnt <= w_cnt_next;
            r_idx <= w_idx_next;
        end
    end

    // Phase FSM: state tracks the phase of the current counter value
    always_ff @(posedge BJ_CLK) begin
        if (!RESET_N) begin
            r_phase <= BLANK;
        end else begin
            r_phase <= w_phase_next;
        end
    end

    always_comb begin
        w_phase_next = SHOW;
        w_show       = 1'b0;
        if (w_cnt_next < c_blank) begin
            w_phase_next = BLANK;
        end
        case (r_phase)
            BLANK:   w_show = 1'b0;
            SHOW:    w_show = 1'b1;
            default: w_show = 1'b0;
        endcase
    end

    // Pending captures any time; active only changes at the frame boundary
    always_ff @(posedge BJ_CLK) begin
        if (!RESET_N) begin
            r_pend_data <= '0;
            r_pend_dp   <= '0;
            r_pend_en   <= '0;
            r_act_data  <= '0;
            r_act_dp    <= '0;
            r_act_en    <= '0;
        end else begin
            if (LOAD) begin
                r_pend_data <= DATA;
                r_pend_dp   <= DP_IN;
                r_pend_en   <= DIGIT_EN;
            end
            if (w_frame_wrap) begin
                r_act_data <= r_pend_data;
                r_act_dp   <= r_pend_dp;
                r_act_en   <= r_pend_en;
            end
        end
    end

    always_comb begin
        w_nib = 4'h0;
        w_dp  = 1'b0;
        w_en  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == c_idx_w'(i)) begin
                w_nib = r_act_data[4*i +: 4];
                w_dp  = r_act_dp[i];
                w_en  = r_act_en[i];
            end
        end
    end

    always_comb begin
        w_seg_dec = 7'h7F;
        case (w_nib)
            4'h0: w_seg_dec = 7'h40;
            4'h1: w_seg_dec = 7'h79;
            4'h2: w_seg_dec = 7'h24;
            4'h3: w_seg_dec = 7'h30;
            4'h4: w_seg_dec = 7'h19;
            4'h5: w_seg_dec = 7'h12;
            4'h6: w_seg_dec = 7'h02;
            4'h7: w_seg_dec = 7'h78;
            4'h8: w_seg_dec = 7'h00;
            4'h9: w_seg_dec = 7'h10;
            4'hA: w_seg_dec = 7'h08;
            4'hB: w_seg_dec = 7'h03;
            4'hC: w_seg_dec = 7'h46;
            4'hD: w_seg_dec = 7'h21;
            4'hE: w_seg_dec = 7'h06;
            4'hF: w_seg_dec = 7'h0E;
            default: w_seg_dec = 7'h7F;
        endcase
    end

    always_comb begin
        w_an_next = '1;
        for (int i = 0; i < DIGITS; i++) begin
            w_an_next[i] = !(w_show && (r_idx == c_idx_w'(i)) && r_act_en[i]);
        end
    end

    // Segments latch on the first blank cycle of a slot, so they never move under a lit anode
    always_ff @(posedge BJ_CLK) begin
        if (!RESET_N) begin
            SEG_N      <= 7'h7F;
            DP_N       <= 1'b1;
            AN_N       <= '1;
            FRAME_DONE <= 1'b0;
        end else begin
            AN_N       <= w_an_next;
            FRAME_DONE <= w_frame_wrap;
            if (r_cnt == '0) begin
                SEG_N <= w_en ? w_seg_dec : 7'h7F;
                DP_N  <= ~w_dp;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan
//  Brief    : Randomized bench for seg7_scan against a frame/slot arithmetic model.
//  Revision : 1.0
// ============================================================================
module tb_seg7_scan;

    localparam int D  = 4;
    localparam int S  = 10;
    localparam int B  = 2;
    localparam int FR = D * S;

    localparam logic [6:0] SEGTAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load;
    logic [15:0]   data;
    logic [3:0]    dp_in;
    logic [3:0]    en;
    logic [6:0]    seg_n;
    logic          dp_n;
    logic [3:0]    an_n;
    logic          fd;

    seg7_scan #(
        .DIGITS       (D),
        .SLOT_CYCLES  (S),
        .BLANK_CYCLES (B)
    ) dut (
        .BJ_CLK     (clk),
        .RESET_N    (rst_n),
        .LOAD       (load),
        .DATA       (data),
        .DP_IN      (dp_in),
        .DIGIT_EN   (en),
        .SEG_N      (seg_n),
        .DP_N       (dp_n),
        .AN_N       (an_n),
        .FRAME_DONE (fd)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: edge count since reset release gives frame position directly
    int          mk = 0;
    bit          m_valid = 1'b0;
    logic [15:0] m_pd, m_ad;
    logic [3:0]  m_pdp, m_adp, m_pen, m_aen;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_fd;

    always @(posedge clk) begin
        int p, d, c;
        if (!rst_n) begin
            mk = 0;
            m_pd = '0; m_ad = '0; m_pdp = '0; m_adp = '0; m_pen = '0; m_aen = '0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            mk++;
            p = (mk - 1) % FR;
            d = p / S;
            c = p % S;
            e_an = 4'hF;
            if (c >= B && m_aen[d]) e_an[d] = 1'b0;
            e_seg = m_aen[d] ? SEGTAB[m_ad[4*d +: 4]] : 7'h7F;
            e_dp  = ~m_adp[d];
            e_fd  = (mk % FR == 0);
            if (mk % FR == 0) begin
                m_ad = m_pd; m_adp = m_pdp; m_aen = m_pen;
            end
            if (load) begin
                m_pd = data; m_pdp = dp_in; m_pen = en;
            end
        end
    end

    logic [6:0] prev_seg;
    bit         have_prev = 1'b0;

    always @(negedge clk) begin
        if (m_valid) begin
            chk("an_n", an_n, e_an);
            chk("seg_n", seg_n, e_seg);
            chk("dp_n", dp_n, e_dp);
            chk("frame_done", fd, e_fd);
            chk("an_at_most_one", ($countones(~an_n) <= 1), 1);
            if (have_prev && seg_n !== prev_seg) chk("seg_change_blank", an_n, 4'hF);
            prev_seg  = seg_n;
            have_prev = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int target);
        int guard = 0;
        while (mk < target && guard < 10000) begin
            tick();
            guard++;
        end
        if (mk != target) chk("run_to_timeout", mk, target);
    endtask

    task automatic pin(input string nm, input logic [3:0] an, input logic [6:0] sg, input logic dp);
        chk({nm, "_an"}, an_n, an);
        chk({nm, "_seg"}, seg_n, sg);
        chk({nm, "_dp"}, dp_n, dp);
    endtask

    task automatic do_load(input logic [15:0] dv, input logic [3:0] dpv, input logic [3:0] ev);
        load = 1'b1; data = dv; dp_in = dpv; en = ev;
        tick();
        load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; data = '0; dp_in = '0; en = '0;
        repeat (3) tick();
        pin("reset", 4'hF, 7'h7F, 1'b1);
        chk("reset_fd", fd, 0);
        rst_n = 1'b1;

        run_to(3);
        chk("dark_an_e3", an_n, 4'hF);
        run_to(4);
        do_load(16'h1A08, 4'b0010, 4'hF);
        run_to(40);
        chk("fd_e40", fd, 1);
        run_to(41);
        chk("fd_e41", fd, 0);
        run_to(42);
        pin("d0_blank", 4'hF, 7'h00, 1'b1);
        run_to(43);
        pin("d0_show", 4'b1110, 7'h00, 1'b1);
        run_to(50);
        chk("d0_last_show", an_n, 4'b1110);
        run_to(51);
        pin("d1_blank", 4'hF, 7'h40, 1'b0);
        run_to(53);
        pin("d1_show", 4'b1101, 7'h40, 1'b0);
        run_to(63);
        pin("d2_show", 4'b1011, 7'h08, 1'b1);
        run_to(73);
        pin("d3_show", 4'b0111, 7'h79, 1'b1);
        run_to(80);
        chk("fd_e80", fd, 1);

        run_to(85);
        do_load(16'h1234, 4'b0000, 4'b0101);
        run_to(123);
        pin("en_d0", 4'b1110, 7'h19, 1'b1);
        run_to(133);
        pin("en_d1_dark", 4'hF, 7'h7F, 1'b1);
        run_to(143);
        pin("en_d2", 4'b1011, 7'h24, 1'b1);

        run_to(150);
        do_load(16'h1111, 4'b0000, 4'hF);
        run_to(159);
        do_load(16'h2222, 4'b0000, 4'hF);
        run_to(163);
        pin("bnd_old", 4'b1110, 7'h79, 1'b1);
        run_to(203);
        pin("bnd_new", 4'b1110, 7'h24, 1'b1);

        run_to(225);
        chk("pre_reset_d2", an_n, 4'b1011);
        rst_n = 1'b0;
        tick();
        pin("mid_reset", 4'hF, 7'h7F, 1'b1);
        rst_n = 1'b1;
        run_to(1);
        do_load(16'hFFFF, 4'b0000, 4'hF);
        run_to(38);
        chk("post_reset_dark", an_n, 4'hF);
        run_to(42);
        pin("restart_blank", 4'hF, 7'h0E, 1'b1);
        run_to(43);
        pin("restart_show", 4'b1110, 7'h0E, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 799) != 0);
            load  = ($urandom_range(0, 7) == 0);
            data  = 16'($urandom);
            dp_in = 4'($urandom);
            en    = 4'($urandom);
            tick();
        end
        rst_n = 1'b1;
        load  = 1'b0;
        repeat (FR) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
